// File: rtl/chunked_addsub.sv
// chunked_addsub: multi-cycle W-bit adder/subtractor processing one CHUNK-bit slice per clock,
// with carry/borrow, zero and signed-overflow flags behind valid/ready handshakes.
module chunked_addsub #(
    parameter int W     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         sub,
    input  logic         cin,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         zero,
    output logic         overflow,
    output logic         busy
);
    localparam int NCHUNK = W / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if (W % CHUNK != 0) begin : g_bad_chunk
            $error("chunked_addsub: W must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          r_state;
    logic [KW-1:0]   r_k;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_c;
    logic            r_sub;
    logic [CHUNK:0]  w_sum;
    logic [W-1:0]    w_res;
    logic            w_cmsb;
    logic            w_last;

    // On the last slice the slice MSB is the word MSB, so its carry-in falls out of the sum bit.
    always_comb begin
        w_sum  = {1'b0, r_a[r_k*CHUNK +: CHUNK]} + {1'b0, r_b[r_k*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, r_c};
        w_res  = result;
        w_res[r_k*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
        w_cmsb = w_sum[CHUNK-1] ^ r_a[W-1] ^ r_b[W-1];
        w_last = (r_k == KW'(NCHUNK - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_k      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= 1'b0;
            r_sub    <= 1'b0;
            result   <= '0;
            carry    <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_a     <= a;
                    r_b     <= sub ? ~b : b;
                    r_c     <= sub ^ cin;
                    r_sub   <= sub;
                    r_k     <= '0;
                    r_state <= BUSY;
                end
                BUSY: begin
                    result <= w_res;
                    r_c    <= w_sum[CHUNK];
                    if (w_last) begin
                        carry    <= r_sub ^ w_sum[CHUNK];
                        zero     <= (w_res == '0);
                        overflow <= w_cmsb ^ w_sum[CHUNK];
                        r_state  <= DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                DONE: if (out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == BUSY);
    assign out_valid = (r_state == DONE);
endmodule

// File: doc/chunked_addsub.md
Name: chunked_addsub

Overview:
- Parametrised, multi-cycle W-bit adder/subtractor with the full flag set: Carry, Zero and signed Overflow.
- Each operation is split into CHUNK-bit slices, and one slice is processed per clock. This trades latency for a short carry chain.
- Operands enter through a valid/ready input handshake; results leave through a valid/ready output handshake.
- The block is the arithmetic datapath for the ALU and sits between the operand-select stage and the writeback register.

Parameters:
- W, 32, operand and result width. W must be divisible by CHUNK; elaboration fails otherwise.
- CHUNK, 8, bits processed per BUSY cycle. Setting CHUNK = W gives a single BUSY cycle.
- NCHUNK (localparam), W/CHUNK, number of BUSY cycles per operation.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  operand set present.
- in_ready  out  1  block can accept operands; high only in IDLE.
- sub  in  1  0 = add, 1 = subtract.
- cin  in  1  carry-in for add, borrow-in for subtract.
- a  in  W  operand A (two's complement or unsigned).
- b  in  W  operand B.
- out_valid  out  1  result and flags valid; high only in DONE.
- out_ready  in  1  consumer takes the result.
- result  out  W  sum or difference.
- carry  out  1  add: carry-out; subtract: borrow-out (inverted adder carry-out).
- zero  out  1  result == 0.
- overflow  out  1  signed overflow.
- busy  out  1  high in BUSY.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to IDLE and the chunk counter to 0.
  - result, carry, zero, overflow, out_valid and busy are 0; in_ready is 1.
  - Reset takes effect at any state, including mid-BUSY. A partial result is discarded and no out_valid is produced for it.
- FSM IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid high:
    - latch a;
    - latch b_eff = sub ? ~b : b;
    - set carry_reg = sub ? ~cin : cin;
    - clear the counter and go to BUSY.
  - Inputs are not sampled in any other state.
- BUSY, one slice per edge:
  - At counter value k, slice k covers bits [k*CHUNK +: CHUNK].
  - {c, s} = a_slice + b_eff_slice + carry_reg; s is stored into result bits of slice k; carry_reg <= c.
  - On the slice with k = NCHUNK-1:
    - capture the carry into the MSB (needed for overflow);
    - go to DONE.
  - Otherwise increment k.
- Flags are computed on entry to DONE and registered:
  - carry = sub ? ~carry_reg : carry_reg.
  - overflow = carry_into_MSB XOR carry_reg_out. This is equivalent to a[W-1] == b_eff[W-1] and result[W-1] != a[W-1].
  - zero = (result == 0).
- Latency:
  - out_valid rises NCHUNK+1 edges after the accepting edge.
  - That is one accept edge plus NCHUNK BUSY edges, registered into DONE.
  - Throughput is one operation per NCHUNK+2 cycles with out_ready held high.
- DONE:
  - out_valid = 1.
  - result and all flags stay stable until an edge with out_ready high, then the FSM goes to IDLE.
  - out_valid is never dropped without a handshake.
  - result and flags hold their last values in IDLE and BUSY; consumers use them only when out_valid is high.
- Simultaneous events:
  - A new in_valid while in DONE is ignored (in_ready = 0); the producer must hold it.
  - in_valid toggling during BUSY has no effect.
- Width rules:
  - All arithmetic is modulo 2^W. cin is exactly one bit added at the LSB of slice 0.
  - No sign extension is performed; signedness only affects interpretation of overflow.

Test Plan (W=8, CHUNK=4, NCHUNK=2 unless stated):
- Add with signed overflow: a=0x7F, b=0x01, sub=0, cin=0.
  -> out_valid 3 edges after accept; result=0x80, carry=0, zero=0, overflow=1.
- Add wrap to zero: a=0xFF, b=0x01, cin=0.
  -> result=0x00, carry=1, zero=1, overflow=0.
- Add with cin rippling across the slice boundary: a=0x0F, b=0x00, cin=1.
  -> result=0x10, carry=0, overflow=0.
- Subtract, unsigned borrow: sub=1, a=0x00, b=0x01, cin=0.
  -> result=0xFF, carry(borrow)=1, overflow=0.
- Subtract, signed overflow: a=0x80, b=0x01.
  -> result=0x7F, carry=0, overflow=1.
- Subtract with borrow-in: a=0x05, b=0x03, cin=1.
  -> result=0x01, carry=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid with new operands.
  -> result and flags unchanged, in_ready=0, out_valid=1.
  -> after out_ready=1 for one edge: out_valid=0, in_ready=1, and the next operation produces its own correct result.
- Reset mid-operation: assert rst_n=0 asynchronously in the first BUSY cycle.
  -> same cycle: busy=0, out_valid=0, result=0, in_ready=1.
  -> after release, a fresh 0x12+0x34 yields 0x46 with no stale out_valid.
- Parameter sweep: W=32 with CHUNK=8, and W=16 with CHUNK=16 (single slice).
  -> 10k random add/sub operations with random cin match the reference model for result, carry, zero and overflow.
  -> latency is exactly NCHUNK+1 edges in both configurations.
